// File: rtl/game_state_ctrl.sv
// Game-flow controller for the runner game: idle/play/pause/hit/over sequencing,
// score ticking, level progression, multi-life respawn and high-score tracking.
module game_state_ctrl #(
  parameter int unsigned SCORE_W        = 14,
  parameter int unsigned TICK_DIV       = 1000000,
  parameter int unsigned LEVEL_W        = 3,
  parameter int unsigned LEVEL_STEP     = 100,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned RESPAWN_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enter,
  input  logic               pause,
  input  logic               collision,
  output logic [2:0]         state,
  output logic               run_en,
  output logic               clear_field,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score,
  output logic [LEVEL_W-1:0] level,
  output logic [3:0]         lives_left
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned STEP_W = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;
  localparam int unsigned RSP_W  = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_HIT   = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               enter_q, pause_q;
  logic               enter_rise_q, pause_rise_q;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [RSP_W-1:0]   rsp_q, rsp_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] hi_q, hi_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [3:0]         lives_q, lives_d;
  logic               run_en_q;
  logic               clear_q, clear_d;
  logic               new_game;
  logic               score_inc;

  // Button edge detect; history resets high so a held button is not a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enter_q      <= 1'b1;
      pause_q      <= 1'b1;
      enter_rise_q <= 1'b0;
      pause_rise_q <= 1'b0;
    end else begin
      enter_q      <= enter;
      pause_q      <= pause;
      enter_rise_q <= enter & ~enter_q;
      pause_rise_q <= pause & ~pause_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    step_d    = step_q;
    rsp_d     = rsp_q;
    score_d   = score_q;
    hi_d      = hi_q;
    level_d   = level_q;
    lives_d   = lives_q;
    clear_d   = 1'b0;
    new_game  = 1'b0;
    score_inc = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enter_rise_q) begin
          state_d  = ST_PLAY;
          new_game = 1'b1;
        end
      end

      ST_PLAY: begin
        if (tick_q == TICK_W'(TICK_DIV - 1)) begin
          tick_d    = '0;
          score_inc = (score_q != '1);
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end

        // Score, step and level all freeze once the score saturates.
        if (score_inc) begin
          score_d = score_q + SCORE_W'(1);
          if (step_q == STEP_W'(LEVEL_STEP - 1)) begin
            step_d = '0;
            if (level_q != '1) level_d = level_q + LEVEL_W'(1);
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end

        // Collision outranks pause; hi-score sees this cycle's increment.
        if (collision) begin
          tick_d = '0;
          rsp_d  = '0;
          if (lives_q > 4'd1) begin
            lives_d = lives_q - 4'd1;
            state_d = ST_HIT;
          end else begin
            lives_d = 4'd0;
            state_d = ST_OVER;
            if (score_d > hi_q) hi_d = score_d;
          end
        end else if (pause_rise_q) begin
          state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (pause_rise_q || enter_rise_q) state_d = ST_PLAY;
      end

      ST_HIT: begin
        if (rsp_q == RSP_W'(RESPAWN_CYCLES - 1)) begin
          state_d = ST_PLAY;
          clear_d = 1'b1;
        end else begin
          rsp_d = rsp_q + RSP_W'(1);
        end
      end

      ST_OVER: begin
        if (enter_rise_q) begin
          state_d  = ST_PLAY;
          new_game = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (new_game) begin
      score_d = '0;
      level_d = '0;
      lives_d = 4'(LIVES);
      tick_d  = '0;
      step_d  = '0;
      clear_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      step_q   <= '0;
      rsp_q    <= '0;
      score_q  <= '0;
      hi_q     <= '0;
      level_q  <= '0;
      lives_q  <= 4'd0;
      run_en_q <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      step_q   <= step_d;
      rsp_q    <= rsp_d;
      score_q  <= score_d;
      hi_q     <= hi_d;
      level_q  <= level_d;
      lives_q  <= lives_d;
      run_en_q <= (state_d == ST_PLAY);
      clear_q  <= clear_d;
    end
  end

  assign state       = state_q;
  assign run_en      = run_en_q;
  assign clear_field = clear_q;
  assign score       = score_q;
  assign hi_score    = hi_q;
  assign level       = level_q;
  assign lives_left  = lives_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with small parameters so every
// score, level, respawn and saturation boundary is reached quickly.
module tb_game_state_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enter;
  logic       pause;
  logic       collision;
  logic [2:0] state;
  logic       run_en;
  logic       clear_field;
  logic [3:0] score;
  logic [3:0] hi_score;
  logic [1:0] level;
  logic [3:0] lives_left;

  int tests  = 0;
  int failed = 0;

  game_state_ctrl #(
    .SCORE_W(4), .TICK_DIV(4), .LEVEL_W(2), .LEVEL_STEP(3),
    .LIVES(2), .RESPAWN_CYCLES(5)
  ) dut (
    .clk(clk), .reset(reset), .enter(enter), .pause(pause),
    .collision(collision), .state(state), .run_en(run_en),
    .clear_field(clear_field), .score(score), .hi_score(hi_score),
    .level(level), .lives_left(lives_left)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enter = 1'b0; pause = 1'b0; collision = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  // Ends just after the edge on which the game enters PLAY (tick=0).
  task automatic start_game();
    enter = 1'b0; cyc(1);
    enter = 1'b1; cyc(1);
    enter = 1'b0; cyc(1);
  endtask

  task automatic test_reset();
    reset = 1'b1; enter = 1'b0; pause = 1'b0; collision = 1'b0;
    cyc(2);
    tests++; if (state !== 3'd0) begin failed++; $display("FAIL rst_state got %0d exp 0", state); end
    tests++; if ({run_en, clear_field} !== 2'b00) begin failed++; $display("FAIL rst_flags got %b exp 00", {run_en, clear_field}); end
    tests++; if ({score, hi_score, level, lives_left} !== 14'd0) begin failed++; $display("FAIL rst_counters got %h exp 0", {score, hi_score, level, lives_left}); end
    reset = 1'b0;
    cyc(2);
    tests++; if (state !== 3'd0) begin failed++; $display("FAIL rst_idle_hold got %0d exp 0", state); end
  endtask

  task automatic test_start();
    enter = 1'b0; cyc(1);
    enter = 1'b1; cyc(1);
    tests++; if (state !== 3'd0) begin failed++; $display("FAIL start_latency got %0d exp 0", state); end
    enter = 1'b0; cyc(1);
    tests++; if (state !== 3'd1) begin failed++; $display("FAIL start_state got %0d exp 1", state); end
    tests++; if (lives_left !== 4'd2) begin failed++; $display("FAIL start_lives got %0d exp 2", lives_left); end
    tests++; if ({run_en, clear_field} !== 2'b11) begin failed++; $display("FAIL start_pulse got %b exp 11", {run_en, clear_field}); end
    cyc(1);
    tests++; if (clear_field !== 1'b0) begin failed++; $display("FAIL start_clear_once got %b exp 0", clear_field); end
    cyc(11);
    tests++; if (score !== 4'd3) begin failed++; $display("FAIL start_score got %0d exp 3", score); end
    tests++; if (level !== 2'd1) begin failed++; $display("FAIL start_level got %0d exp 1", level); end
  endtask

  task automatic test_pause();
    do_reset();
    start_game();
    cyc(8);
    tests++; if (score !== 4'd2) begin failed++; $display("FAIL pause_pre_score got %0d exp 2", score); end
    pause = 1'b1; cyc(1);
    pause = 1'b0; cyc(1);
    tests++; if ({state, run_en} !== {3'd2, 1'b0}) begin failed++; $display("FAIL pause_enter got %0d/%b exp 2/0", state, run_en); end
    for (int i = 0; i < 20; i++) begin
      collision = i[1];
      cyc(1);
    end
    collision = 1'b0;
    tests++; if ({state, score, lives_left} !== {3'd2, 4'd2, 4'd2}) begin failed++; $display("FAIL pause_frozen got st=%0d sc=%0d lv=%0d exp 2/2/2", state, score, lives_left); end
    pause = 1'b1; cyc(1);
    pause = 1'b0; cyc(1);
    tests++; if ({state, score} !== {3'd1, 4'd2}) begin failed++; $display("FAIL pause_resume got st=%0d sc=%0d exp 1/2", state, score); end
    cyc(1);
    tests++; if (score !== 4'd2) begin failed++; $display("FAIL pause_tick3 got %0d exp 2", score); end
    cyc(1);
    tests++; if (score !== 4'd3) begin failed++; $display("FAIL pause_tick_held got %0d exp 3", score); end
  endtask

  task automatic test_respawn();
    do_reset();
    start_game();
    cyc(1);
    collision = 1'b1; cyc(1);
    collision = 1'b0;
    tests++; if ({state, lives_left, run_en} !== {3'd3, 4'd1, 1'b0}) begin failed++; $display("FAIL hit_enter got st=%0d lv=%0d run=%b exp 3/1/0", state, lives_left, run_en); end
    cyc(4);
    tests++; if (state !== 3'd3) begin failed++; $display("FAIL hit_hold got %0d exp 3", state); end
    cyc(1);
    tests++; if ({state, clear_field, run_en} !== {3'd1, 1'b1, 1'b1}) begin failed++; $display("FAIL hit_exit got st=%0d clr=%b run=%b exp 1/1/1", state, clear_field, run_en); end
    cyc(1);
    tests++; if (clear_field !== 1'b0) begin failed++; $display("FAIL hit_clear_once got %b exp 0", clear_field); end
  endtask

  task automatic test_game_over();
    do_reset();
    start_game();
    collision = 1'b1; cyc(1);
    collision = 1'b0; cyc(5);
    cyc(28);
    tests++; if (score !== 4'd7) begin failed++; $display("FAIL over_pre_score got %0d exp 7", score); end
    collision = 1'b1; cyc(1);
    collision = 1'b0;
    tests++; if ({state, lives_left, hi_score} !== {3'd4, 4'd0, 4'd7}) begin failed++; $display("FAIL over_enter got st=%0d lv=%0d hi=%0d exp 4/0/7", state, lives_left, hi_score); end
    cyc(3);
    tests++; if ({score, level, run_en} !== {4'd7, 2'd2, 1'b0}) begin failed++; $display("FAIL over_display got sc=%0d lvl=%0d run=%b exp 7/2/0", score, level, run_en); end
    start_game();
    tests++; if ({state, score, lives_left, hi_score, level} !== {3'd1, 4'd0, 4'd2, 4'd7, 2'd0}) begin failed++; $display("FAIL over_restart got st=%0d sc=%0d lv=%0d hi=%0d lvl=%0d exp 1/0/2/7/0", state, score, lives_left, hi_score, level); end
    cyc(20);
    collision = 1'b1; cyc(1);
    collision = 1'b0; cyc(5);
    collision = 1'b1; cyc(1);
    collision = 1'b0;
    tests++; if ({state, score, hi_score} !== {3'd4, 4'd5, 4'd7}) begin failed++; $display("FAIL over_lower_game got st=%0d sc=%0d hi=%0d exp 4/5/7", state, score, hi_score); end
  endtask

  task automatic test_saturation_priority();
    do_reset();
    start_game();
    cyc(60);
    tests++; if ({score, level} !== {4'd15, 2'd3}) begin failed++; $display("FAIL sat_reach got sc=%0d lvl=%0d exp 15/3", score, level); end
    cyc(40);
    tests++; if ({state, score, level} !== {3'd1, 4'd15, 2'd3}) begin failed++; $display("FAIL sat_hold got st=%0d sc=%0d lvl=%0d exp 1/15/3", state, score, level); end
    pause = 1'b1; cyc(1);
    pause = 1'b0; collision = 1'b1; cyc(1);
    collision = 1'b0;
    tests++; if ({state, lives_left} !== {3'd3, 4'd1}) begin failed++; $display("FAIL prio_hit got st=%0d lv=%0d exp 3/1", state, lives_left); end
    cyc(5);
    pause = 1'b1; cyc(1);
    pause = 1'b0; collision = 1'b1; cyc(1);
    collision = 1'b0;
    tests++; if ({state, lives_left, hi_score} !== {3'd4, 4'd0, 4'd15}) begin failed++; $display("FAIL prio_over got st=%0d lv=%0d hi=%0d exp 4/0/15", state, lives_left, hi_score); end
  endtask

  task automatic test_collide_on_tick();
    do_reset();
    start_game();
    collision = 1'b1; cyc(1);
    collision = 1'b0; cyc(5);
    cyc(3);
    collision = 1'b1; cyc(1);
    collision = 1'b0;
    tests++; if ({state, score, hi_score} !== {3'd4, 4'd1, 4'd1}) begin failed++; $display("FAIL tick_collide got st=%0d sc=%0d hi=%0d exp 4/1/1", state, score, hi_score); end
  endtask

  task automatic test_reset_behaviour();
    reset = 1'b1; enter = 1'b1; pause = 1'b0; collision = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(4);
    tests++; if (state !== 3'd0) begin failed++; $display("FAIL held_enter got %0d exp 0", state); end
    start_game();
    tests++; if (state !== 3'd1) begin failed++; $display("FAIL held_then_press got %0d exp 1", state); end
    cyc(10);
    #2;
    reset = 1'b1;
    #1;
    tests++; if (state !== 3'd0) begin failed++; $display("FAIL async_state got %0d exp 0", state); end
    tests++; if ({run_en, clear_field, score, hi_score, level, lives_left} !== 16'd0) begin failed++; $display("FAIL async_outputs got %h exp 0", {run_en, clear_field, score, hi_score, level, lives_left}); end
    cyc(1);
    reset = 1'b0;
    cyc(1);
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause();
    test_respawn();
    test_game_over();
    test_saturation_priority();
    test_collide_on_tick();
    test_reset_behaviour();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
Parametrised game-flow controller for the runner game. It replaces the two-bit start/run/over FSM with a five-state machine that adds pause, multi-life respawn, score ticking, level progression and high-score tracking. Sits between the button/collision inputs and the obstacle, sprite and score-display logic. Downstream blocks advance only while run_en=1.

Parameters:
SCORE_W, 14, score and high-score width in bits.
TICK_DIV, 1000000, clk cycles per score point while playing (must be >=2).
LEVEL_W, 3, level counter width.
LEVEL_STEP, 100, score points per level increment (must be >=1).
LIVES, 3, lives per game (1..15).
RESPAWN_CYCLES, 50000000, clk cycles spent in HIT before play resumes (must be >=1).

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high; clears all state.
enter  input  1  start/resume button, already synchronised; block acts on rising edge only.
pause  input  1  pause toggle button, already synchronised; acts on rising edge only.
collision  input  1  level-sensitive hit flag from collision detector.
state  output  3  IDLE=0, PLAY=1, PAUSE=2, HIT=3, OVER=4.
run_en  output  1  high only in PLAY.
clear_field  output  1  one-cycle pulse: obstacles must reset.
score  output  SCORE_W  current score.
hi_score  output  SCORE_W  best final score since reset.
level  output  LEVEL_W  difficulty level.
lives_left  output  4  remaining lives.

Behaviour:
- Reset (async): state=IDLE; score, hi_score, level, lives_left, tick and step counters=0; run_en=0; clear_field=0. enter_q and pause_q reset to 1, so a button held through reset does not count as a press.
- Edge detect: enter_rise = enter & ~enter_q; pause_rise = pause & ~pause_q. Both are registered every cycle.
- New-game init, applied on the IDLE->PLAY or OVER->PLAY transition cycle: score=0, level=0, lives_left=LIVES, tick=0, step=0, clear_field=1 for that one cycle.
- IDLE: enter_rise -> PLAY with new-game init. pause and collision are ignored.
- PLAY:
  - tick increments every cycle. At tick==TICK_DIV-1, tick wraps to 0 and score increments.
  - On each score increment, step increments. At step==LEVEL_STEP-1, step wraps and level increments, saturating at 2^LEVEL_W-1.
  - Score saturates at 2^SCORE_W-1. Once saturated, score, step and level freeze.
  - collision has highest priority:
    - If lives_left>1: lives_left decrements, next state=HIT.
    - If lives_left==1: lives_left=0, next state=OVER, and hi_score=max(hi_score, score) on the same edge.
  - Otherwise, pause_rise -> PAUSE. enter is ignored.
  - Collision and score tick on the same cycle: the score increment still applies, and the hi_score compare uses the incremented value.
- PAUSE: all counters hold. pause_rise or enter_rise -> PLAY, with tick preserved. collision is ignored.
- HIT:
  - On entry, tick=0 and the respawn counter=0. Respawn counter increments each cycle.
  - At respawn==RESPAWN_CYCLES-1 -> PLAY, with clear_field=1 on that transition cycle.
  - score and level hold. pause and enter are ignored.
- OVER: score and level hold for display. enter_rise -> PLAY with new-game init; hi_score is retained.
- All outputs are registered. run_en = (state==PLAY) and is decoded from the state register, so it changes on the same edge as state.
- Latency: a press is seen on the edge after enter rises; state changes on the following edge. Two cycles from the enter rising edge to state=PLAY.
- Reset asserted mid-game returns to IDLE immediately and clears hi_score.
- Unused encodings 5-7 recover to IDLE on the next edge.

Test Plan:
Bench parameters: SCORE_W=4, TICK_DIV=4, LEVEL_W=2, LEVEL_STEP=3, LIVES=2, RESPAWN_CYCLES=5.
1. Start: release reset, pulse enter for 1 cycle -> state=1, lives_left=2, clear_field high exactly 1 cycle. After 12 PLAY cycles, score=3 and level=1.
2. Pause: in PLAY with score=2, pulse pause -> state=2, score frozen for 20 cycles, collision pulses ignored. Pulse pause again -> state=1 and ticking resumes from the held tick value.
3. Respawn: collision in PLAY with lives_left=2 -> state=3, lives_left=1, run_en=0. After 5 cycles, state=1 with a single clear_field pulse.
4. Game over: second collision with score=7 -> state=4, lives_left=0, hi_score=7. Enter -> state=1, score=0, lives_left=2, hi_score stays 7. A later game ending at score 5 leaves hi_score=7.
5. Saturation and priority: play until score=15 and level=3, then both stay fixed. Collision and pause_rise in the same cycle -> collision wins (HIT or OVER).
6. Reset behaviour: enter held high across reset release -> stays IDLE until enter is released and pressed again. Async reset asserted mid-PLAY -> state=0, all outputs 0, before the next clk edge.
